// File: rtl/spi_slave_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_fifo_pkg : shared types and constants for the SPI slave |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_slave_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // Shortest character is MIN_CHAR_LEN+1 bits; shorter requests are widened.
   localparam int          MIN_CHAR_LEN      = 3;
   localparam logic [31:0] DEF_UNDERRUN_CHAR = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/spi_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_sync_fifo : single-clock FIFO, simultaneous push/pop when full |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int              c_aw         = $clog2(DEPTH);
   localparam logic [c_aw:0]   c_full_level = (c_aw+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_aw:0]    level_q, level_d;
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
   always_comb begin
      do_pop   = i_pop & (level_q != '0);
      do_push  = i_push & ((level_q != c_full_level) | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + 1'b1;
      end else if (!do_push && do_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[rd_ptr_q];
   assign o_full  = (level_q == c_full_level);
   assign o_empty = (level_q == '0);
   assign o_level = level_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_fifo : oversampled SPI slave, 4 modes, TX/RX FIFOs       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_slave_fifo
   import spi_slave_fifo_pkg::*;
#(
   parameter int                    CHAR_NBITS    = 16,
   parameter int                    FIFO_DEPTH    = 8,
   parameter logic [CHAR_NBITS-1:0] UNDERRUN_CHAR = DEF_UNDERRUN_CHAR[CHAR_NBITS-1:0]
) (
   input  logic                            S_SYSCLK,
   input  logic                            S_RESET,
   input  logic                            S_ENABLE,
   input  logic                            S_CPOL,
   input  logic                            S_CPHA,
   input  logic                            S_REV,
   input  logic [$clog2(CHAR_NBITS)-1:0]   S_CHAR_LEN,
   input  logic                            S_SPI_SCK,
   input  logic                            S_SPI_CS_B,
   input  logic                            S_SPI_MOSI,
   output logic                            S_SPI_MISO,
   output logic                            S_SPI_MISO_OE,
   input  logic [CHAR_NBITS-1:0]           S_TX_WDATA,
   input  logic                            S_TX_WVALID,
   output logic                            S_TX_WREADY,
   output logic [CHAR_NBITS-1:0]           S_RX_RDATA,
   output logic                            S_RX_RVALID,
   input  logic                            S_RX_RREADY,
   output logic [$clog2(FIFO_DEPTH):0]     S_TX_LEVEL,
   output logic [$clog2(FIFO_DEPTH):0]     S_RX_LEVEL,
   output logic                            S_OVERRUN,
   output logic                            S_UNDERRUN,
   output logic                            S_FRAME_ERR,
   input  logic                            S_STATUS_CLR,
   output logic                            S_BUSY
);

   localparam int                c_clw        = $clog2(CHAR_NBITS);
   localparam logic [c_clw-1:0]  c_min_len_m1 = c_clw'(MIN_CHAR_LEN);

   state_e                  state_q, state_d;
   logic [2:0]              sck_sync_q, sck_sync_d;
   logic [2:0]              cs_sync_q, cs_sync_d;
   logic [1:0]              mosi_sync_q, mosi_sync_d;
   logic                    cpol_q, cpol_d, cpha_q, cpha_d, rev_q, rev_d;
   logic [c_clw-1:0]        len_m1_q, len_m1_d;
   logic [c_clw:0]          cnt_q, cnt_d;
   logic [CHAR_NBITS-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [CHAR_NBITS-1:0]   rx_data_q, rx_data_d;
   logic                    rx_push_q, rx_push_d;
   logic                    miso_q, miso_d, oe_q, oe_d;
   logic                    overrun_q, overrun_d, underrun_q, underrun_d;
   logic                    frame_err_q, frame_err_d;

   logic                    sck_rise, sck_fall, lead_edge, trail_edge;
   logic                    sample_edge, shift_edge, cs_fall, abort, partial;
   logic [c_clw:0]          char_len;
   logic [CHAR_NBITS-1:0]   rx_next, load_word, tx_rdata;
   logic                    tx_pop, tx_full, tx_empty, rx_full, rx_empty;
   logic                    underrun_set, frame_set, overrun_set;

   // Index [1] is the synchronized level, index [2] its one-cycle-old copy.
   assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
   assign lead_edge   = cpol_q ? sck_fall : sck_rise;
   assign trail_edge  = cpol_q ? sck_rise : sck_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge : trail_edge;
   assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
   assign abort       = cs_sync_q[1] | ~S_ENABLE;
   assign char_len    = {1'b0, len_m1_q} + 1'b1;
   assign partial     = (cnt_q != '0) && (cnt_q != char_len);

   always_comb begin
      sck_sync_d   = {sck_sync_q[1:0], S_SPI_SCK};
      cs_sync_d    = {cs_sync_q[1:0], S_SPI_CS_B};
      mosi_sync_d  = {mosi_sync_q[0], S_SPI_MOSI};
      state_d      = state_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      rev_d        = rev_q;
      len_m1_d     = len_m1_q;
      cnt_d        = cnt_q;
      tx_sr_d      = tx_sr_q;
      rx_sr_d      = rx_sr_q;
      rx_data_d    = rx_data_q;
      rx_push_d    = 1'b0;
      miso_d       = miso_q;
      oe_d         = oe_q;
      tx_pop       = 1'b0;
      underrun_set = 1'b0;
      frame_set    = 1'b0;
      load_word    = UNDERRUN_CHAR;
      // LSB-first chars enter at bit L-1 and walk down, leaving them right-justified.
      rx_next      = rev_q ? {rx_sr_q[CHAR_NBITS-2:0], mosi_sync_q[1]} : (rx_sr_q >> 1);
      if (!rev_q) begin
         rx_next[len_m1_q] = mosi_sync_q[1];
      end

      unique case (state_q)
         ST_IDLE: begin
            oe_d = 1'b0;
            if (S_ENABLE && cs_fall) begin
               cpol_d   = S_CPOL;
               cpha_d   = S_CPHA;
               rev_d    = S_REV;
               len_m1_d = (S_CHAR_LEN < c_min_len_m1) ? c_min_len_m1 : S_CHAR_LEN;
               cnt_d    = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD, ST_SHIFT: begin
            if (abort) begin
               frame_set = partial;
               oe_d      = 1'b0;
               miso_d    = 1'b0;
               state_d   = ST_IDLE;
            end else if (state_q == ST_LOAD) begin
               if (!tx_empty) begin
                  tx_pop    = 1'b1;
                  load_word = tx_rdata;
               end else begin
                  underrun_set = 1'b1;
               end
               tx_sr_d = load_word;
               rx_sr_d = '0;
               cnt_d   = '0;
               miso_d  = rev_q ? load_word[len_m1_q] : load_word[0];
               oe_d    = 1'b1;
               state_d = ST_SHIFT;
            end else if (sample_edge) begin
               rx_sr_d = rx_next;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_d == char_len) begin
                  rx_push_d = 1'b1;
                  rx_data_d = rx_next;
                  state_d   = ST_LOAD;
               end
            end else if (shift_edge && (cnt_q != '0)) begin
               // cnt_q==0 skips the first leading edge in CPHA=1: LOAD already drove bit 0.
               tx_sr_d = rev_q ? (tx_sr_q << 1) : (tx_sr_q >> 1);
               miso_d  = rev_q ? tx_sr_q[len_m1_q - 1'b1] : tx_sr_q[1];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pop-before-push: a concurrent RX read makes room, so no overrun is flagged.
   assign overrun_set = rx_push_q & rx_full & ~(S_RX_RREADY & ~rx_empty);
   assign overrun_d   = overrun_set  | (overrun_q   & ~S_STATUS_CLR);
   assign underrun_d  = underrun_set | (underrun_q  & ~S_STATUS_CLR);
   assign frame_err_d = frame_set    | (frame_err_q & ~S_STATUS_CLR);

   always_ff @(posedge S_SYSCLK) begin
      if (S_RESET) begin
         state_q     <= ST_IDLE;
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         rev_q       <= 1'b0;
         len_m1_q    <= c_min_len_m1;
         cnt_q       <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_push_q   <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         rev_q       <= rev_d;
         len_m1_q    <= len_m1_d;
         cnt_q       <= cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_push_q   <= rx_push_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (S_SYSCLK),
      .rst     (S_RESET),
      .i_push  (S_TX_WVALID),
      .i_wdata (S_TX_WDATA),
      .i_pop   (tx_pop),
      .o_rdata (tx_rdata),
      .o_full  (tx_full),
      .o_empty (tx_empty),
      .o_level (S_TX_LEVEL)
   );

   spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (S_SYSCLK),
      .rst     (S_RESET),
      .i_push  (rx_push_q),
      .i_wdata (rx_data_q),
      .i_pop   (S_RX_RREADY),
      .o_rdata (S_RX_RDATA),
      .o_full  (rx_full),
      .o_empty (rx_empty),
      .o_level (S_RX_LEVEL)
   );

   assign S_SPI_MISO    = miso_q;
   assign S_SPI_MISO_OE = oe_q;
   assign S_TX_WREADY   = ~tx_full;
   assign S_RX_RVALID   = ~rx_empty;
   assign S_OVERRUN     = overrun_q;
   assign S_UNDERRUN    = underrun_q;
   assign S_FRAME_ERR   = frame_err_q;
   assign S_BUSY        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
- Synthesizable, parametrised SPI slave. Successor to the fixed 16-bit behavioural slave model.
- Adds all four CPOL/CPHA modes, runtime char length, MSB/LSB-first order, and TX/RX FIFOs with overrun/underrun/frame-error status.
- Sits opposite spi_intface on the SPI pins, either in loopback benches or as an on-chip peripheral endpoint.
- All logic runs on S_SYSCLK; SPI pins are oversampled.

Parameters:
- CHAR_NBITS, 16, maximum character width in bits (4..32).
- FIFO_DEPTH, 8, entries per TX and RX FIFO (power of two, >=2).
- UNDERRUN_CHAR, all ones, value shifted out when the TX FIFO is empty.

Ports:
- S_SYSCLK  in  1  system clock; must be >= 4x SCK.
- S_RESET  in  1  synchronous, active-high reset.
- S_ENABLE  in  1  block enable; 0 ignores CS_B and holds S_SPI_MISO_OE low.
- S_CPOL  in  1  clock polarity.
- S_CPHA  in  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- S_REV  in  1  1 = MSB first, 0 = LSB first.
- S_CHAR_LEN  in  $clog2(CHAR_NBITS)  bits-per-char minus 1.
- S_SPI_SCK  in  1  serial clock (asynchronous).
- S_SPI_CS_B  in  1  chip select, active low (asynchronous).
- S_SPI_MOSI  in  1  serial data in.
- S_SPI_MISO  out  1  serial data out.
- S_SPI_MISO_OE  out  1  MISO output enable (1 while selected).
- S_TX_WDATA  in  CHAR_NBITS  TX char, right-justified.
- S_TX_WVALID  in  1  TX push request.
- S_TX_WREADY  out  1  TX FIFO not full.
- S_RX_RDATA  out  CHAR_NBITS  RX FIFO head, right-justified, upper bits zero.
- S_RX_RVALID  out  1  RX FIFO not empty.
- S_RX_RREADY  in  1  RX pop.
- S_TX_LEVEL  out  $clog2(FIFO_DEPTH)+1  TX occupancy.
- S_RX_LEVEL  out  $clog2(FIFO_DEPTH)+1  RX occupancy.
- S_OVERRUN  out  1  sticky: RX char dropped because the RX FIFO was full.
- S_UNDERRUN  out  1  sticky: TX FIFO empty at a char load.
- S_FRAME_ERR  out  1  sticky: CS_B deasserted mid-character.
- S_STATUS_CLR  in  1  clears all three sticky flags.
- S_BUSY  out  1  frame in progress.

Behaviour:
- Reset values: S_SPI_MISO=0, S_SPI_MISO_OE=0, FIFOs empty, S_TX_WREADY=1, S_RX_RVALID=0, both levels 0, all sticky flags 0, S_BUSY=0, FSM in IDLE.
- Input sync: SCK, CS_B and MOSI each pass through a 2-flop synchronizer. Edge detect uses a third flop, so pin-to-event latency is 3 cycles.
- Edge definitions: leading edge = SCK leaving its S_CPOL level; trailing edge = SCK returning to it.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading (except the first leading edge of each char), sample on trailing.
- IDLE: wait for synced CS_B falling edge with S_ENABLE=1.
  - Latch CPOL, CPHA, REV and effective length L = max(S_CHAR_LEN,3)+1. Config is frozen until return to IDLE.
  - Go to LOAD.
- LOAD (1 cycle):
  - TX FIFO not empty: pop it into the shift register.
  - TX FIFO empty: load UNDERRUN_CHAR and set S_UNDERRUN.
  - Clear the bit counter, drive the first bit on S_SPI_MISO, set S_SPI_MISO_OE=1. Go to SHIFT.
  - First bit is bit L-1 when REV=1, bit 0 when REV=0.
- SHIFT: on each sample edge, shift in synced MOSI and increment the counter. On each shift edge, present the next TX bit.
- When the counter reaches L on a sample edge:
  - Push the assembled char to the RX FIFO next cycle. If RX is full, drop the char and set S_OVERRUN.
  - CS_B still low: go to LOAD for the next char (continuous frames).
- CS_B rising in LOAD/SHIFT:
  - Counter 0 or L: normal end.
  - Otherwise: discard the partial char and set S_FRAME_ERR.
  - Either way, MISO_OE=0 and go to IDLE within 1 cycle of the synced edge.
- S_ENABLE=0 mid-frame is handled like CS_B rising: abort, with S_FRAME_ERR set if partial.
- Simultaneous events:
  - External TX push while LOAD pops: both occur, level unchanged.
  - RX push and S_RX_RREADY pop with RX full: pop first, so no overrun.
  - S_STATUS_CLR coinciding with a new error event: set wins.
- FIFO behaviour: pointers wrap modulo FIFO_DEPTH. Writes when full and reads when empty are ignored.
- S_BUSY = (state != IDLE).
- S_RESET mid-frame returns all state to reset values on the next edge.

Decomposition:
- Shared include (alongside the register bit definitions) holds:
  - FSM state encodings ST_IDLE/ST_LOAD/ST_SHIFT.
  - MIN_CHAR_LEN=3.
  - Default UNDERRUN_CHAR.
- One sub-module, spi_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), instantiated twice for TX and RX.

Test Plan:
- Mode 0, L=8, REV=1, TX FIFO preloaded 0xA5: master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RX FIFO holds 0x003C; no flags set.
- Each of modes 1/2/3 with L=16, REV=0: master sends 0x55AA, TX preloaded 0x1234 -> RX=0x55AA, master receives 0x1234 in all four modes.
- Continuous frame of 3 chars (L=8), TX FIFO holding only 1 entry -> chars 2 and 3 transmit 0xFF, S_UNDERRUN=1, RX level 3.
- RX FIFO filled to FIFO_DEPTH with no pops, then one more char -> char dropped, S_OVERRUN=1, RX level stays 8; S_STATUS_CLR clears the flag.
- CS_B raised after 5 of 8 bits -> no RX push, S_FRAME_ERR=1, MISO_OE=0, FSM in IDLE; the next full frame is received correctly.
- S_CHAR_LEN=1 (below minimum) -> treated as 4-bit chars; S_RESET asserted mid-char -> all outputs at reset values next cycle.
